// File: rtl/float_pkg.sv
// Shared constants for the pipelined floating-point adder.
// Holds format defaults, pipeline depth, flag bit positions and the
// canonical quiet-NaN encoding as a function of the format widths.
package float_pkg;

  localparam int unsigned EXP_W_DEF  = 8;
  localparam int unsigned FRAC_W_DEF = 23;
  localparam int unsigned LATENCY    = 4;

  localparam int unsigned FLAG_W        = 3;
  localparam int unsigned FLAG_INVALID  = 2;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INEXACT  = 0;

  // Sign 0, exponent all-ones, only the fraction MSB set; caller truncates to W.
  function automatic logic [63:0] canon_nan(input int unsigned exp_w,
                                            input int unsigned frac_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << frac_w;
    r = r | (64'd1 << (frac_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Leading-zero counter.
// Ports: in_bits (WIDTH) value to scan from MSB down;
//        cnt_c (CNT_W) number of leading zeros, WIDTH when in_bits is zero.
module float_lzc #(
  parameter int unsigned WIDTH = 27,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [CNT_W-1:0] cnt_c
);

  logic found;

  // Priority scan: the first set bit from the top fixes the count.
  always_comb begin
    cnt_c = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!found && in_bits[i]) begin
        cnt_c = CNT_W'(int'(WIDTH) - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_add_pipe.sv
// Four-stage pipelined IEEE-style adder/subtractor, round-to-nearest-even,
// subnormals flushed to zero.
// Ports: clk, rst_n (sync, active-low); a, b, sub, in_valid, in_ready (input
// handshake); z, flags {invalid, overflow, inexact}, out_valid, out_ready
// (output handshake). in_ready is combinational: low only while stalled.
module float_add_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          sub,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    flags
);

  localparam int unsigned M_W   = FRAC_W + 1;      // mantissa with hidden bit
  localparam int unsigned X_W   = FRAC_W + 4;      // mantissa + guard/round/sticky
  localparam int unsigned S_W   = X_W + 1;         // plus carry-out
  localparam int unsigned LZ_W  = $clog2(X_W + 1);
  localparam int unsigned E_W   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
  localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, FRAC_W));

  logic stall, advance;
  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d, v2_d, v3_d, v4_d;

  // S1 state
  logic              s1_sign_d, s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_d, s1_exp_q;
  logic [M_W-1:0]    s1_mbig_d, s1_mbig_q;
  logic [M_W-1:0]    s1_msml_d, s1_msml_q;
  logic [EXP_W-1:0]  s1_diff_d, s1_diff_q;
  logic              s1_esub_d, s1_esub_q;
  logic              s1_spc_d, s1_spc_q;
  logic [W-1:0]      s1_spcz_d, s1_spcz_q;
  logic [2:0]        s1_spcf_d, s1_spcf_q;
  // S2 state
  logic              s2_sign_q;
  logic [EXP_W-1:0]  s2_exp_q;
  logic [X_W-1:0]    s2_xbig_d, s2_xbig_q;
  logic [X_W-1:0]    s2_xsml_d, s2_xsml_q;
  logic              s2_esub_q;
  logic              s2_spc_q;
  logic [W-1:0]      s2_spcz_q;
  logic [2:0]        s2_spcf_q;
  // S3 state
  logic              s3_sign_q;
  logic [EXP_W-1:0]  s3_exp_q;
  logic [S_W-1:0]    s3_sum_d, s3_sum_q;
  logic [LZ_W-1:0]   s3_lz_d, s3_lz_q;
  logic              s3_spc_q;
  logic [W-1:0]      s3_spcz_q;
  logic [2:0]        s3_spcf_q;
  // S4 state (outputs)
  logic [W-1:0]      z_d, z_q;
  logic [2:0]        flags_d, flags_q;

  // Handshake: the whole pipe freezes while the output is held.
  assign stall     = v4_q && !out_ready;
  assign advance   = !stall;
  assign in_ready  = advance;
  assign out_valid = v4_q;
  assign z         = z_q;
  assign flags     = flags_q;

  always_comb begin
    v1_d = in_valid;
    v2_d = v1_q;
    v3_d = v2_q;
    v4_d = v3_q;
  end

  // S1: unpack, flush subnormals, detect specials, order by magnitude.
  always_comb begin
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [W-2:0]     a_mag, b_mag, big_mag, sml_mag;
    sa     = a[W-1];
    sb     = b[W-1] ^ sub;
    ea     = a[W-2:FRAC_W];
    eb     = b[W-2:FRAC_W];
    a_zero = ~|ea;
    b_zero = ~|eb;
    a_inf  = (&ea) && !(|a[FRAC_W-1:0]);
    b_inf  = (&eb) && !(|b[FRAC_W-1:0]);
    a_nan  = (&ea) && (|a[FRAC_W-1:0]);
    b_nan  = (&eb) && (|b[FRAC_W-1:0]);
    a_mag  = a_zero ? '0 : a[W-2:0];
    b_mag  = b_zero ? '0 : b[W-2:0];
    swap   = b_mag > a_mag;
    big_mag = swap ? b_mag : a_mag;
    sml_mag = swap ? a_mag : b_mag;

    s1_sign_d = swap ? sb : sa;
    s1_exp_d  = big_mag[W-2:FRAC_W];
    s1_mbig_d = {|big_mag[W-2:FRAC_W], big_mag[FRAC_W-1:0]};
    s1_msml_d = {|sml_mag[W-2:FRAC_W], sml_mag[FRAC_W-1:0]};
    s1_diff_d = big_mag[W-2:FRAC_W] - sml_mag[W-2:FRAC_W];
    s1_esub_d = sa ^ sb;

    s1_spc_d  = 1'b0;
    s1_spcz_d = '0;
    s1_spcf_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_spc_d                = 1'b1;
      s1_spcz_d               = QNAN;
      s1_spcf_d[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      s1_spc_d  = 1'b1;
      s1_spcz_d = {sa, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (b_inf) begin
      s1_spc_d  = 1'b1;
      s1_spcz_d = {sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      // Only (-0)+(-0) keeps a negative sign.
      s1_spc_d  = 1'b1;
      s1_spcz_d = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // S2: align the smaller operand; shifted-out bits collapse into sticky.
  always_comb begin
    logic [X_W-1:0] ext_sml, mask;
    s2_xbig_d = {s1_mbig_q, 3'b000};
    ext_sml   = {s1_msml_q, 3'b000};
    mask      = ~({X_W{1'b1}} << s1_diff_q);
    if (32'(s1_diff_q) >= (FRAC_W + 3)) begin
      s2_xsml_d = X_W'(|s1_msml_q);
    end else begin
      s2_xsml_d = (ext_sml >> s1_diff_q) | X_W'(|(ext_sml & mask));
    end
  end

  // S3: magnitude add/subtract; big >= small so the difference is non-negative.
  always_comb begin
    if (s2_esub_q) begin
      s3_sum_d = {1'b0, s2_xbig_q} - {1'b0, s2_xsml_q};
    end else begin
      s3_sum_d = {1'b0, s2_xbig_q} + {1'b0, s2_xsml_q};
    end
  end

  float_lzc #(.WIDTH(X_W)) u_lzc (
    .in_bits (s3_sum_d[X_W-1:0]),
    .cnt_c   (s3_lz_d)
  );

  // S4: normalise, round to nearest even, pack, resolve specials.
  always_comb begin
    logic [X_W-1:0]    norm;
    logic [E_W-1:0]    exp_n, exp_r;
    logic [FRAC_W+1:0] mant_r;
    logic [FRAC_W-1:0] frac;
    logic              inexact, up;
    if (s3_sum_q[X_W]) begin
      norm  = {s3_sum_q[X_W:2], |s3_sum_q[1:0]};
      exp_n = E_W'(s3_exp_q) + E_W'(1);
    end else begin
      norm  = s3_sum_q[X_W-1:0] << s3_lz_q;
      exp_n = E_W'(s3_exp_q) - E_W'(s3_lz_q);
    end
    inexact = |norm[2:0];
    up      = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r  = {1'b0, norm[X_W-1:3]} + (FRAC_W+2)'(up);
    // Rounding carry-out: mantissa becomes 1.000..., bump the exponent.
    if (mant_r[FRAC_W+1]) begin
      exp_r = exp_n + E_W'(1);
      frac  = mant_r[FRAC_W:1];
    end else begin
      exp_r = exp_n;
      frac  = mant_r[FRAC_W-1:0];
    end

    z_d     = '0;
    flags_d = '0;
    if (s3_spc_q) begin
      z_d     = s3_spcz_q;
      flags_d = s3_spcf_q;
    end else if (s3_sum_q == '0) begin
      z_d = '0;
    end else if (exp_n[E_W-1] || (exp_n == '0)) begin
      z_d                   = '0;
      flags_d[FLAG_INEXACT] = 1'b1;
    end else if (exp_r >= E_W'({EXP_W{1'b1}})) begin
      z_d                    = {s3_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
    end else begin
      z_d                   = {s3_sign_q, exp_r[EXP_W-1:0], frac};
      flags_d[FLAG_INEXACT] = inexact;
    end
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      z_q     <= '0;
      flags_q <= '0;
    end else if (advance) begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      v4_q    <= v4_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  // Datapath registers: no reset, contents ignored when the stage is empty.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_mbig_q <= s1_mbig_d;
      s1_msml_q <= s1_msml_d;
      s1_diff_q <= s1_diff_d;
      s1_esub_q <= s1_esub_d;
      s1_spc_q  <= s1_spc_d;
      s1_spcz_q <= s1_spcz_d;
      s1_spcf_q <= s1_spcf_d;

      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_xbig_q <= s2_xbig_d;
      s2_xsml_q <= s2_xsml_d;
      s2_esub_q <= s1_esub_q;
      s2_spc_q  <= s1_spc_q;
      s2_spcz_q <= s1_spcz_q;
      s2_spcf_q <= s1_spcf_q;

      s3_sign_q <= s2_sign_q;
      s3_exp_q  <= s2_exp_q;
      s3_sum_q  <= s3_sum_d;
      s3_lz_q   <= s3_lz_d;
      s3_spc_q  <= s2_spc_q;
      s3_spcz_q <= s2_spcz_q;
      s3_spcf_q <= s2_spcf_q;
    end
  end

endmodule

// File: tb/tb_float_add_pipe.sv
// Scoreboard bench for float_add_pipe: single precision instance plus a
// half-precision (EXP_W=5, FRAC_W=10) instance.
module tb_float_add_pipe;

  typedef struct packed {
    logic [31:0] z;
    logic [2:0]  f;
    logic        lat;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, z;
  logic        sub, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  flags;

  logic [15:0] h_a, h_b, h_z;
  logic        h_sub, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [2:0]  h_flags;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t hq[$];
  exp_t me, mh;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  float_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .flags(flags)
  );

  float_add_pipe #(.EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .a(h_a), .b(h_b), .sub(h_sub), .in_valid(h_in_valid),
    .in_ready(h_in_ready), .z(h_z), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .flags(h_flags)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: single-precision outputs and stall/in_ready relation.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output z=%h", z);
        end else begin
          me = q.pop_front();
          check("z", z, me.z);
          check("flags", 32'(flags), 32'(me.f));
          if (me.lat) check("latency", 32'(cyc) - me.cyc, 32'd4);
        end
      end
    end
  end

  // Monitor: half-precision outputs.
  always @(negedge clk) begin
    if (rst_n && h_out_valid && h_out_ready) begin
      if (hq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_half_output z=%h", h_z);
      end else begin
        mh = hq.pop_front();
        check("half_z", 32'(h_z), mh.z);
        check("half_flags", 32'(h_flags), 32'(mh.f));
      end
    end
  end

  // Present one operation; called just after a rising edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic s,
                      input logic [31:0] ez, input logic [2:0] ef, input logic lat);
    int waited = 0;
    a = av; b = bv; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout a=%h b=%h", av, bv);
    end else begin
      q.push_back('{z: ez, f: ef, lat: lat, cyc: 32'(cyc)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ez, input logic [2:0] ef);
    int waited = 0;
    h_a = av; h_b = bv; h_sub = 1'b0; h_in_valid = 1'b1;
    @(negedge clk);
    while (!h_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!h_in_ready) begin
      checks++;
      errors++;
      $display("FAIL half_send_timeout a=%h b=%h", av, bv);
    end else begin
      hq.push_back('{z: 32'(ez), f: ef, lat: 1'b0, cyc: 32'(cyc)});
    end
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || hq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || hq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size() + hq.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0; h_sub = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_z", z, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors: basic sum (latency checked), ties, specials, boundaries
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b1);
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 1'b0);
    send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1'b0);
    send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 1'b0);
    send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 1'b0);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1'b0);
    send(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 1'b0);
    send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 1'b0);
    send(32'h7F7FFFFF, 32'h3F800000, 1'b0, 32'h7F7FFFFF, 3'b001, 1'b0);
    send(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, 1'b0);
    drain();

    // Back-pressure: 8 back-to-back inputs, out_ready low in cycles 5..7
    @(posedge clk);
    #1;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 1'b0);
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000, 1'b0);
        send(32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 3'b000, 1'b0);
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 3'b000, 1'b0);
        send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 3'b000, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight: they must never emerge
    @(posedge clk);
    #1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 1'b0);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_output_after_reset", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h40000000, 32'h3F000000, 1'b0, 32'h40200000, 3'b000, 1'b1);
    drain();

    // Half precision format
    @(posedge clk);
    #1;
    send_h(16'h3C00, 16'h3C00, 16'h4000, 3'b000);
    send_h(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
